// File: rtl/sdio_xfer_scheduler.sv
// SDIO transaction scheduler: accepts decoded host commands, returns R5 responses
// and launches CMD53 data blocks one at a time, tracking CRC, timeout and I/O abort.
module sdio_xfer_scheduler #(
  parameter int MAX_BLK_BYTES  = 512,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = 16
) (
  input  logic        axi_clk,
  input  logic        axi_resetn,
  input  logic        cmd_valid,
  input  logic [47:0] cmd_reg,
  input  logic        cmd_crc_err,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [5:0]  rsp_index,
  output logic [31:0] rsp_arg,
  input  logic        rsp_ready,
  output logic        xfer_start,
  output logic        xfer_dir,
  output logic [9:0]  xfer_len,
  input  logic        xfer_done,
  input  logic        xfer_crc_err,
  output logic [8:0]  blk_remaining,
  output logic        busy,
  output logic        xfer_end,
  output logic [1:0]  xfer_status
);

  typedef enum logic [2:0] {S_IDLE, S_RESP, S_START, S_WAIT, S_DONE} state_e;

  localparam logic [1:0]       ST_OK    = 2'b00;
  localparam logic [1:0]       ST_CRC   = 2'b01;
  localparam logic [1:0]       ST_TMO   = 2'b10;
  localparam logic [1:0]       ST_ABORT = 2'b11;
  localparam logic [9:0]       BLK_LEN  = 10'(MAX_BLK_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic [5:0]       rsp_index_q, rsp_index_d;
  logic [31:0]      rsp_arg_q, rsp_arg_d;
  logic             go53_q, go53_d;
  logic             blkmode_q, blkmode_d;
  logic             pdir_q, pdir_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [9:0]       len_q, len_d;
  logic [8:0]       blk_rem_q, blk_rem_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             abort_q, abort_d;
  logic [1:0]       status_q, status_d;
  logic             sticky_q, sticky_d;
  logic             start_q;

  logic [5:0]  c_idx;
  logic [31:0] c_arg;
  logic        c_is52, c_is53, c_illegal, c_abort;
  logic [7:0]  c_flags;
  logic        in_wait, accept, rsp_hs;
  logic        unused_cmd_bits;

  assign c_idx   = cmd_reg[45:40];
  assign c_arg   = cmd_reg[39:8];
  assign c_is52  = (c_idx == 6'd52);
  assign c_is53  = (c_idx == 6'd53);
  assign in_wait = (state_q == S_WAIT);

  assign unused_cmd_bits = ^{cmd_reg[47:46], c_arg[26], cmd_reg[7:0]};

  // While a transfer runs only CMD52 is serviced; everything else is answered ILLEGAL.
  assign c_illegal = in_wait ? ~c_is52
                             : (~(c_is52 | c_is53) |
                                (c_is53 & c_arg[27] & (c_arg[8:0] == 9'd0)));
  assign c_flags   = {cmd_crc_err, c_illegal, (in_wait ? 2'b10 : 2'b01), sticky_q, 3'b000};

  assign cmd_ready = ((state_q == S_IDLE) || in_wait) && !rsp_pend_q;
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_hs    = rsp_pend_q & rsp_ready;

  // CMD52 write of CCCR 0x06 (I/O abort) in function 0.
  assign c_abort = accept & in_wait & c_is52 & ~cmd_crc_err & c_arg[31] &
                   (c_arg[30:28] == 3'd0) & (c_arg[25:9] == 17'h00006);

  always_comb begin
    state_d     = state_q;
    rsp_pend_d  = rsp_pend_q;
    rsp_index_d = rsp_index_q;
    rsp_arg_d   = rsp_arg_q;
    go53_d      = go53_q;
    blkmode_d   = blkmode_q;
    pdir_d      = pdir_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    len_d       = len_q;
    blk_rem_d   = blk_rem_q;
    tmo_d       = tmo_q;
    abort_d     = abort_q;
    status_d    = status_q;
    sticky_d    = sticky_q;

    if (rsp_hs) rsp_pend_d = 1'b0;
    // The response slot is shared by IDLE commands and commands arriving during WAIT.
    if (accept) begin
      rsp_pend_d  = 1'b1;
      rsp_index_d = c_idx;
      rsp_arg_d   = {16'h0000, c_flags, 8'h00};
      sticky_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          state_d   = S_RESP;
          go53_d    = c_is53 & ~c_illegal & ~cmd_crc_err;
          blkmode_d = c_arg[27];
          pdir_d    = c_arg[31];
          cnt_d     = c_arg[8:0];
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          if (go53_q) begin
            state_d   = S_START;
            dir_d     = pdir_q;
            blk_rem_d = blkmode_q ? cnt_q : 9'd1;
            len_d     = (blkmode_q || (cnt_q == 9'd0)) ? BLK_LEN : {1'b0, cnt_q};
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An abort accepted now only affects later blocks: the decision below uses abort_q.
        if (c_abort) abort_d = 1'b1;
        if (xfer_done) begin
          if (xfer_crc_err) begin
            status_d = ST_CRC;
            state_d  = S_DONE;
          end else begin
            if (blk_rem_q != 9'd0) blk_rem_d = blk_rem_q - 9'd1;
            if ((blk_rem_q <= 9'd1) || abort_q) begin
              status_d = abort_q ? ST_ABORT : ST_OK;
              state_d  = S_DONE;
            end else begin
              state_d = S_START;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (status_q != ST_OK) sticky_d = 1'b1;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= S_IDLE;
      rsp_pend_q  <= 1'b0;
      rsp_index_q <= '0;
      rsp_arg_q   <= '0;
      go53_q      <= 1'b0;
      blkmode_q   <= 1'b0;
      pdir_q      <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      len_q       <= '0;
      blk_rem_q   <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      status_q    <= ST_OK;
      sticky_q    <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_index_q <= rsp_index_d;
      rsp_arg_q   <= rsp_arg_d;
      go53_q      <= go53_d;
      blkmode_q   <= blkmode_d;
      pdir_q      <= pdir_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      blk_rem_q   <= blk_rem_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      status_q    <= status_d;
      sticky_q    <= sticky_d;
      start_q     <= (state_q == S_START);
    end
  end

  assign rsp_valid     = rsp_pend_q;
  assign rsp_index     = rsp_index_q;
  assign rsp_arg       = rsp_arg_q;
  assign xfer_start    = start_q;
  assign xfer_dir      = dir_q;
  assign xfer_len      = len_q;
  assign blk_remaining = blk_rem_q;
  assign busy          = (state_q != S_IDLE);
  assign xfer_end      = (state_q == S_DONE);
  assign xfer_status   = (state_q == S_DONE) ? status_q : ST_OK;

endmodule

// File: tb/tb_sdio_xfer_scheduler.sv
// Directed bench for sdio_xfer_scheduler: command/response, block sequencing,
// CRC and timeout errors, sticky error flag, I/O abort and mid-transfer reset.
module tb_sdio_xfer_scheduler;

  logic        axi_clk = 1'b0;
  logic        axi_resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [47:0] cmd_reg = '0;
  logic        cmd_crc_err = 1'b0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;
  logic        rsp_ready = 1'b0;
  logic        xfer_start;
  logic        xfer_dir;
  logic [9:0]  xfer_len;
  logic        xfer_done = 1'b0;
  logic        xfer_crc_err = 1'b0;
  logic [8:0]  blk_remaining;
  logic        busy;
  logic        xfer_end;
  logic [1:0]  xfer_status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int end_cnt = 0;

  always #5 axi_clk = ~axi_clk;

  sdio_xfer_scheduler #(
    .MAX_BLK_BYTES (512),
    .TIMEOUT_CYCLES(16),
    .TMO_W         (16)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_resetn   (axi_resetn),
    .cmd_valid    (cmd_valid),
    .cmd_reg      (cmd_reg),
    .cmd_crc_err  (cmd_crc_err),
    .cmd_ready    (cmd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_index    (rsp_index),
    .rsp_arg      (rsp_arg),
    .rsp_ready    (rsp_ready),
    .xfer_start   (xfer_start),
    .xfer_dir     (xfer_dir),
    .xfer_len     (xfer_len),
    .xfer_done    (xfer_done),
    .xfer_crc_err (xfer_crc_err),
    .blk_remaining(blk_remaining),
    .busy         (busy),
    .xfer_end     (xfer_end),
    .xfer_status  (xfer_status)
  );

  always @(posedge axi_clk) cyc <= cyc + 1;

  always @(negedge axi_clk) begin
    if (xfer_start) start_cnt <= start_cnt + 1;
    if (xfer_end)   end_cnt   <= end_cnt + 1;
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic crc);
    int n = 0;
    cmd_reg     = {2'b01, idx, arg, 8'h01};
    cmd_valid   = 1'b1;
    cmd_crc_err = crc;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept idx=%0d: cmd_ready=%b required 1", idx, cmd_ready);
    end
    tick();
    cmd_valid   = 1'b0;
    cmd_crc_err = 1'b0;
  endtask

  task automatic get_rsp(output logic [5:0] idx, output logic [31:0] arg);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 50 cycles", rsp_valid);
      idx = 6'h3f;
      arg = 32'hdead_beef;
    end else begin
      idx = rsp_index;
      arg = rsp_arg;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_start(output int at);
    int n = 0;
    while (!xfer_start && n < 50) begin tick(); n++; end
    checks++;
    if (xfer_start !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: xfer_start=%b required 1 within 50 cycles", xfer_start);
      at = -1;
    end else begin
      at = cyc;
    end
  endtask

  task automatic pulse_done(input logic crc, output int at);
    xfer_done    = 1'b1;
    xfer_crc_err = crc;
    at = cyc;
    tick();
    xfer_done    = 1'b0;
    xfer_crc_err = 1'b0;
  endtask

  task automatic wait_end(output int at, output logic [1:0] st, output logic [8:0] rem);
    int n = 0;
    while (!xfer_end && n < 60) begin tick(); n++; end
    checks++;
    if (xfer_end !== 1'b1) begin
      errors++;
      $display("FAIL end_wait: xfer_end=%b required 1 within 60 cycles", xfer_end);
      at = -1; st = 2'bxx; rem = 9'h1ff;
    end else begin
      at = cyc; st = xfer_status; rem = blk_remaining;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({cmd_ready, rsp_valid, xfer_start, busy, xfer_end} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: {rdy,rv,st,busy,end}=%b required 10000",
               {cmd_ready, rsp_valid, xfer_start, busy, xfer_end});
    end
    axi_resetn = 1'b1;
    tick();
    checks++;
    if ({rsp_index, rsp_arg, xfer_dir, xfer_len, blk_remaining, xfer_status} !== '0 ||
        cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: idx=%0d arg=%h len=%0d rem=%0d st=%b rdy=%b required zeros/rdy=1",
               rsp_index, rsp_arg, xfer_len, blk_remaining, xfer_status, cmd_ready);
    end
  endtask

  task automatic test_cmd52_read();
    logic [5:0] i; logic [31:0] a; int s0;
    s0 = start_cnt;
    send_cmd(6'd52, 32'h0000_0000, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL c52_busy_resp: busy=%b required 1", busy); end
    get_rsp(i, a);
    checks++;
    if (i !== 6'd52 || a !== 32'h0000_1000) begin
      errors++; $display("FAIL c52_rsp: idx=%0d arg=%h required 52 00001000", i, a);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || start_cnt != s0) begin
      errors++; $display("FAIL c52_idle: busy=%b starts=%0d required 0 0", busy, start_cnt - s0);
    end
  endtask

  task automatic test_illegal_idle();
    logic [5:0] i; logic [31:0] a; int s0;
    s0 = start_cnt;
    send_cmd(6'd53, 32'h8800_0003, 1'b1);
    get_rsp(i, a);
    checks++;
    if (i !== 6'd53 || a !== 32'h0000_9000) begin
      errors++; $display("FAIL crc_cmd_rsp: idx=%0d arg=%h required 53 00009000", i, a);
    end
    send_cmd(6'd53, 32'h0800_0000, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_5000) begin
      errors++; $display("FAIL blk0_rsp: arg=%h required 00005000", a);
    end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || start_cnt != s0) begin
      errors++; $display("FAIL illegal_noxfer: busy=%b starts=%0d required 0 0", busy, start_cnt - s0);
    end
  endtask

  task automatic test_block_write();
    logic [5:0] i; logic [31:0] a; int s0, ts, td, te; logic [1:0] st; logic [8:0] rem;
    s0 = start_cnt;
    td = 0;
    send_cmd(6'd53, 32'h8800_0003, 1'b0);
    get_rsp(i, a);
    checks++;
    if (i !== 6'd53 || a !== 32'h0000_1000) begin
      errors++; $display("FAIL bw_rsp: idx=%0d arg=%h required 53 00001000", i, a);
    end
    for (int b = 0; b < 3; b++) begin
      wait_start(ts);
      checks++;
      if (xfer_dir !== 1'b1 || xfer_len !== 10'd512 || blk_remaining !== 9'(3 - b)) begin
        errors++;
        $display("FAIL bw_blk%0d: dir=%b len=%0d rem=%0d required 1 512 %0d",
                 b, xfer_dir, xfer_len, blk_remaining, 3 - b);
      end
      if (b > 0) begin
        checks++;
        if (ts - td != 2) begin
          errors++; $display("FAIL bw_gap%0d: start after done=%0d cycles required 2", b, ts - td);
        end
      end
      repeat (3) tick();
      pulse_done(1'b0, td);
    end
    wait_end(te, st, rem);
    checks++;
    if (st !== 2'b00 || rem !== 9'd0 || start_cnt - s0 != 3) begin
      errors++;
      $display("FAIL bw_end: status=%b rem=%0d starts=%0d required 00 0 3", st, rem, start_cnt - s0);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || xfer_end !== 1'b0) begin
      errors++; $display("FAIL bw_idle: busy=%b end=%b required 0 0", busy, xfer_end);
    end
  endtask

  task automatic test_byte_read();
    logic [5:0] i; logic [31:0] a; int ts, td, te; logic [1:0] st; logic [8:0] rem;
    logic [31:0] args [2];
    logic [9:0]  lens [2];
    args[0] = 32'h0000_0000; lens[0] = 10'd512;
    args[1] = 32'h0000_0011; lens[1] = 10'd17;
    for (int k = 0; k < 2; k++) begin
      send_cmd(6'd53, args[k], 1'b0);
      get_rsp(i, a);
      wait_start(ts);
      checks++;
      if (xfer_dir !== 1'b0 || xfer_len !== lens[k] || blk_remaining !== 9'd1) begin
        errors++;
        $display("FAIL br%0d_blk: dir=%b len=%0d rem=%0d required 0 %0d 1",
                 k, xfer_dir, xfer_len, blk_remaining, lens[k]);
      end
      tick();
      pulse_done(1'b0, td);
      wait_end(te, st, rem);
      checks++;
      if (st !== 2'b00 || rem !== 9'd0 || te - td != 1) begin
        errors++;
        $display("FAIL br%0d_end: status=%b rem=%0d lat=%0d required 00 0 1", k, st, rem, te - td);
      end
      tick();
    end
  endtask

  task automatic test_crc_sticky();
    logic [5:0] i; logic [31:0] a; int ts, td, te; logic [1:0] st; logic [8:0] rem;
    send_cmd(6'd53, 32'h0800_0004, 1'b0);
    get_rsp(i, a);
    wait_start(ts);
    tick();
    pulse_done(1'b0, td);
    wait_start(ts);
    tick();
    pulse_done(1'b1, td);
    wait_end(te, st, rem);
    checks++;
    if (st !== 2'b01 || rem !== 9'd3) begin
      errors++; $display("FAIL crc_end: status=%b rem=%0d required 01 3", st, rem);
    end
    tick();
    send_cmd(6'd52, 32'h0000_0000, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_1800) begin
      errors++; $display("FAIL sticky_set: arg=%h required 00001800", a);
    end
    send_cmd(6'd52, 32'h0000_0000, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_1000) begin
      errors++; $display("FAIL sticky_clr: arg=%h required 00001000", a);
    end
  endtask

  task automatic test_timeout();
    logic [5:0] i; logic [31:0] a; int ts, te; logic [1:0] st; logic [8:0] rem;
    send_cmd(6'd53, 32'h0800_0005, 1'b0);
    get_rsp(i, a);
    wait_start(ts);
    wait_end(te, st, rem);
    checks++;
    if (st !== 2'b10 || rem !== 9'd5 || te - ts != 16) begin
      errors++;
      $display("FAIL tmo_end: status=%b rem=%0d after_start=%0d required 10 5 16", st, rem, te - ts);
    end
    tick();
    send_cmd(6'd52, 32'h0000_0000, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_1800) begin
      errors++; $display("FAIL tmo_sticky: arg=%h required 00001800", a);
    end
  endtask

  task automatic test_abort();
    logic [5:0] i; logic [31:0] a; int s0, ts, td, te; logic [1:0] st; logic [8:0] rem;
    send_cmd(6'd53, 32'h8800_0004, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_1000) begin
      errors++; $display("FAIL ab_rsp53: arg=%h required 00001000", a);
    end
    s0 = start_cnt;
    wait_start(ts);
    send_cmd(6'd52, 32'h8000_0C00, 1'b0);
    get_rsp(i, a);
    checks++;
    if (i !== 6'd52 || a !== 32'h0000_2000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ab_rsp52: idx=%0d arg=%h busy=%b required 52 00002000 1", i, a, busy);
    end
    pulse_done(1'b0, td);
    wait_end(te, st, rem);
    checks++;
    if (st !== 2'b11 || rem !== 9'd3 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL ab_end: status=%b rem=%0d starts=%0d required 11 3 1", st, rem, start_cnt - s0);
    end
    tick();
  endtask

  task automatic test_back_to_back_illegal();
    logic [5:0] i; logic [31:0] a; int ts, td, te; logic [1:0] st; logic [8:0] rem;
    send_cmd(6'd53, 32'h8800_0002, 1'b0);
    get_rsp(i, a);
    checks++;
    if (a !== 32'h0000_1800) begin
      errors++; $display("FAIL il_rsp53: arg=%h required 00001800", a);
    end
    wait_start(ts);
    send_cmd(6'd17, 32'h0000_0000, 1'b0);
    get_rsp(i, a);
    checks++;
    if (i !== 6'd17 || a !== 32'h0000_6000) begin
      errors++; $display("FAIL il_rsp17: idx=%0d arg=%h required 17 00006000", i, a);
    end
    pulse_done(1'b0, td);
    wait_start(ts);
    checks++;
    if (ts - td != 2 || blk_remaining !== 9'd1) begin
      errors++;
      $display("FAIL il_blk2: gap=%0d rem=%0d required 2 1", ts - td, blk_remaining);
    end
    tick();
    pulse_done(1'b0, td);
    wait_end(te, st, rem);
    checks++;
    if (st !== 2'b00 || rem !== 9'd0) begin
      errors++; $display("FAIL il_end: status=%b rem=%0d required 00 0", st, rem);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] i; logic [31:0] a; int ts, e0;
    send_cmd(6'd53, 32'h8800_0003, 1'b0);
    get_rsp(i, a);
    wait_start(ts);
    tick();
    e0 = end_cnt;
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || blk_remaining !== 9'd0 || xfer_len !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b rdy=%b rem=%0d len=%0d required 0 1 0 0",
               busy, cmd_ready, blk_remaining, xfer_len);
    end
    tick();
    tick();
    axi_resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (end_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_noend: ends=%0d busy=%b required 0 0", end_cnt - e0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_cmd52_read();
    test_illegal_idle();
    test_block_write();
    test_byte_read();
    test_crc_sticky();
    test_timeout();
    test_abort();
    test_back_to_back_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdio_xfer_scheduler.md
Name: sdio_xfer_scheduler

Overview:
- Sequences SDIO transactions between the command handler and the data handler, in the axi_clk domain.
- Accepts decoded 48-bit host commands, issues R5 responses back through the command path, and schedules CMD53 block/byte transfers on the data path one block at a time.
- Handles CRC errors, data timeouts and host-issued I/O abort (CMD52 write to CCCR 0x06).

Parameters:
- MAX_BLK_BYTES, 512, block length used in block mode; also the byte-mode length when count=0.
- TIMEOUT_CYCLES, 65535, axi_clk cycles allowed per block before a timeout is declared.
- TMO_W, 16, width of the timeout counter.

Ports:
- axi_clk  in  1  sole clock
- axi_resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  decoded command available
- cmd_reg  in  48  command frame: [45:40] index, [39:8] argument
- cmd_crc_err  in  1  CRC7 failure on the presented command, qualified by cmd_valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- rsp_valid  out  1  response request to the command handler
- rsp_index  out  6  response index (echoes the command index)
- rsp_arg  out  32  R5 argument: {16'h0, flags[7:0], data[7:0]}
- rsp_ready  in  1  response consumed
- xfer_start  out  1  one-cycle pulse that launches one block
- xfer_dir  out  1  1 = host-to-card (write), 0 = card-to-host
- xfer_len  out  10  bytes in this block, 1..512
- xfer_done  in  1  data handler finished the block
- xfer_crc_err  in  1  CRC16 error, qualified by xfer_done
- blk_remaining  out  9  blocks left including the current one
- busy  out  1  high in any state except IDLE
- xfer_end  out  1  one-cycle pulse at transaction end
- xfer_status  out  2  valid with xfer_end: 00 ok, 01 crc, 10 timeout, 11 abort

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State = IDLE; counters and flags cleared. Reset mid-transfer abandons the transfer immediately; no xfer_end is issued.
- States: IDLE, RESP, START, WAIT, DONE.
- IDLE: cmd_ready=1. On accept, latch index and argument, build flags, then go to RESP.
- Flag bits:
  - bit7 = cmd_crc_err
  - bit6 ILLEGAL = index not 52 or 53, or CMD53 block mode with count=0
  - bits5:4 = 01 in IDLE, 10 when a transfer is active
  - bit3 = sticky error from the previous transfer, cleared when it is reported
  - bit0 OUT_OF_RANGE = function field > 7 never (always 0)
- data[7:0] = 0; the CCCR register file lives elsewhere.
- RESP: rsp_valid=1; rsp_index and rsp_arg held stable until rsp_ready. Leave in the cycle after rsp_valid&rsp_ready:
  - to START if the command is CMD53, not illegal, and has no CRC error;
  - otherwise to IDLE.
- CMD53 decode: dir = arg[31]; block mode = arg[27]; count = arg[8:0].
  - Block mode: blk_remaining = count; xfer_len = MAX_BLK_BYTES.
  - Byte mode: blk_remaining = 1; xfer_len = count, with 0 meaning 512.
- START: xfer_start is high for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - xfer_done with crc error: status 01, go to DONE.
  - xfer_done, blk_remaining==1 or abort pending: decrement blk_remaining; status 00 or 11; go to DONE.
  - xfer_done otherwise: decrement blk_remaining; go to START. The next xfer_start therefore occurs 2 cycles after xfer_done.
  - Counter reaches TIMEOUT_CYCLES-1 with no xfer_done: status 10, go to DONE.
  - xfer_done and timeout in the same cycle: xfer_done wins.
- Abort during WAIT:
  - cmd_ready=1 in WAIT, but only CMD52 is serviced. Any other index is answered ILLEGAL and the transfer continues.
  - CMD52 with arg[31]=1, function arg[30:28]=0, address arg[25:9]=0x00006 sets abort-pending.
  - The response goes out via a one-deep pending-response slot that RESP logic drains in parallel with WAIT. rsp_valid may therefore assert while in WAIT; cmd_ready=0 while the slot is full.
  - Abort takes effect at the current block's end. If xfer_done already arrived in the same cycle as the abort accept, the abort does not apply to that block.
- DONE: xfer_end pulses for one cycle with xfer_status. If status≠00, set the sticky error (flag bit3). busy clears; go to IDLE.
- blk_remaining never wraps below 0. It holds 0 after a normal end and the residual count after an error or abort.
- xfer_done is ignored outside WAIT.

Test Plan:
- CMD52 read, arg 0x00000000 → rsp_index=52, rsp_arg=0x00001000, busy=0 afterwards, no xfer_start.
- CMD53 block write, count=3, arg 0x88000003 → response first; then 3 xfer_start pulses, xfer_dir=1, xfer_len=512, each 2 cycles after xfer_done; xfer_end with status 00 and blk_remaining=0.
- CMD53 byte read, count=0 → one block, xfer_len=512, xfer_dir=0. Then CMD53 byte mode, count=17 → xfer_len=17.
- CMD53 count=4 with xfer_crc_err on block 2 → xfer_end status 01, blk_remaining=3; next CMD52 response has flag bit3=1 (rsp_arg=0x00001800), and the following response has bit3=0.
- CMD53 count=5, no xfer_done for TIMEOUT_CYCLES (override to 16) → xfer_end status 10, 16 cycles after xfer_start.
- During block 1 of 4, CMD52 write arg 0x80000C00 → immediate R5 with bits5:4=10; after block 1's xfer_done → xfer_end status 11, blk_remaining=3. Repeat with CMD17 instead → ILLEGAL response (flag 0x60), transfer completes normally.
